serial_sub_ctrl: RTL and testbench

- Bit-serial subtraction controller: accepts WIDTH-bit operands A, B and a borrow-in, then computes D = A - B - BIN one bit per clock, LSB first.
- Each bit passes through a single shared full-subtractor cell; the controller sequences operand shifting and borrow feedback.
- Start/busy/done handshake toward the issuing logic.
- Used where area matters more than latency; it replaces a WIDTH-wide ripple subtractor.

---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/serial_sub_ctrl_fsub_cell.sv | 22 ++
 rtl/serial_sub_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_sub_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared state encoding and default width for serial_sub_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    localparam int C_SUB_WIDTH_DEF = 8;

    // ST_ prefix keeps the literals clear of the DONE port name.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_sub_ctrl_fsub_cell.sv
`default_nettype none
// ============================================================================
// Module      : fsub_cell
// Description : Combinational 1-bit full subtractor (a - b - bin).
// Revision    : 1.0 - initial release
// ============================================================================
module fsub_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    logic w_axb;

    assign w_axb  = i_a ^ i_b;
    assign o_d    = w_axb ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~w_axb & i_bin);

endmodule
`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_ctrl
// Description : Bit-serial subtractor D = A - B - BIN, one bit per clock, LSB
//               first. Define SERIAL_SUB_OVF_EN to add the signed OVF output.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = C_SUB_WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             BOUT
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int             C_CW   = $clog2(WIDTH) + 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-1:0]  r_d_sh;
    logic              r_brw;
    logic [C_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_d;
    logic              r_bout;
    logic              w_d;
    logic              w_bo;
    logic              w_last;
    logic [WIDTH-1:0]  w_d_final;

    fsub_cell u_cell (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_bin  (r_brw),
        .o_d    (w_d),
        .o_bout (w_bo)
    );

    assign w_last    = (r_cnt == C_LAST);
    assign w_d_final = {w_d, r_d_sh[WIDTH-1:1]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_next = START ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: w_next = w_last ? ST_DONE : ST_SHIFT;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_d_sh <= '0;
            r_brw  <= 1'b0;
            r_cnt  <= '0;
            r_d    <= '0;
            r_bout <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (START) begin
                r_a_sh <= A;
                r_b_sh <= B;
                r_brw  <= BIN;
                r_cnt  <= '0;
            end
        end else if (r_state == ST_SHIFT) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_d_sh <= w_d_final;
            r_brw  <= w_bo;
            r_cnt  <= r_cnt + C_CW'(1);
            // Result registers move only on the final bit so partial sums never leak out.
            if (w_last) begin
                r_d    <= w_d_final;
                r_bout <= w_bo;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (START) begin
                r_a_msb <= A[WIDTH-1];
                r_b_msb <= B[WIDTH-1];
            end
        end else if (r_state == ST_SHIFT && w_last) begin
            r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign OVF = r_ovf;
`endif

    assign BUSY = (r_state != ST_IDLE);
    assign DONE = (r_state == ST_DONE);
    assign D    = r_d;
    assign BOUT = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub_ctrl
// Description : Self-checking bench for serial_sub_ctrl (WIDTH = 8), directed
//               cases plus random operands against an integer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub_ctrl;

    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             START = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             BIN = 1'b0;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] D;
    logic             BOUT;
`ifdef SERIAL_SUB_OVF_EN
    logic             OVF;
`endif

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [WIDTH-1:0] prev_d    = '0;
    logic             prev_bout = 1'b0;

    serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .BIN   (BIN),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .D     (D),
        .BOUT  (BOUT)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .OVF   (OVF)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation; reference result is plain integer subtraction.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic bin, input bit junk);
        int               diff;
        logic [WIDTH-1:0] ed;
        logic             eb;
        int               busy_n;
        int               done_n;
        int               done_at;
        bit               held_ok;
        logic [WIDTH-1:0] got_d;
        logic             got_b;
`ifdef SERIAL_SUB_OVF_EN
        logic             got_o;
        logic             eo;
`endif
        diff    = int'(a) - int'(b) - int'(bin);
        ed      = WIDTH'(diff);
        eb      = (diff < 0);
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        held_ok = 1'b1;
        got_d   = 'x;
        got_b   = 1'bx;
`ifdef SERIAL_SUB_OVF_EN
        got_o   = 1'bx;
        eo      = (a[WIDTH-1] != b[WIDTH-1]) && (ed[WIDTH-1] != a[WIDTH-1]);
`endif
        @(negedge CLK);
        START = 1'b1; A = a; B = b; BIN = bin;
        @(negedge CLK);
        START = 1'b0; A = WIDTH'($urandom); B = WIDTH'($urandom); BIN = 1'($urandom);
        for (int cyc = 1; cyc <= WIDTH + 3; cyc++) begin
            if (BUSY) busy_n++;
            if (DONE) begin
                done_n++;
                done_at = cyc;
                got_d   = D;
                got_b   = BOUT;
`ifdef SERIAL_SUB_OVF_EN
                got_o   = OVF;
`endif
            end else if (done_n == 0 && (D !== prev_d || BOUT !== prev_bout)) begin
                held_ok = 1'b0;
            end
            if (junk && (cyc == 3 || cyc == 8)) begin
                START = 1'b1; A = 8'hFF; B = 8'h00;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
        end
        chk("busy_cycles", busy_n, WIDTH + 1);
        chk("done_count", done_n, 1);
        chk("done_latency", done_at, WIDTH + 1);
        chk("result_d", got_d, ed);
        chk("result_bout", got_b, eb);
        chk("hold_before_done", held_ok, 1);
        chk("hold_after_done", D, ed);
`ifdef SERIAL_SUB_OVF_EN
        chk("result_ovf", got_o, eo);
`endif
        prev_d    = ed;
        prev_bout = eb;
    endtask

    initial begin
        int dn;
        int first_at;
        int last_at;
        bit sp_ok;

        #2 RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_d", D, 0);
        chk("rst_bout", BOUT, 0);
        RST = 1'b0;

        do_op(8'h35, 8'h12, 1'b0, 1'b0);
        do_op(8'h00, 8'h01, 1'b0, 1'b0);
        do_op(8'h10, 8'h0F, 1'b1, 1'b0);
        do_op(8'h35, 8'h12, 1'b0, 1'b1);

        // Abort mid-operation with a nonzero result already on D.
        @(negedge CLK);
        START = 1'b1; A = 8'h35; B = 8'h12; BIN = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("abort_busy", BUSY, 0);
        chk("abort_done", DONE, 0);
        chk("abort_d", D, 0);
        chk("abort_bout", BOUT, 0);
        @(negedge CLK);
        RST = 1'b0;
        prev_d = '0; prev_bout = 1'b0;
        do_op(8'h05, 8'h03, 1'b0, 1'b0);

        // START held high: back-to-back operations.
        @(negedge CLK);
        START = 1'b1; A = 8'h01; B = 8'h01; BIN = 1'b0;
        dn = 0; first_at = -1; last_at = -1; sp_ok = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge CLK);
            if (DONE) begin
                dn++;
                chk("b2b_d", D, 0);
                if (first_at < 0) first_at = cyc;
                if (last_at >= 0 && cyc - last_at != WIDTH + 2) sp_ok = 1'b0;
                last_at = cyc;
            end
            if (cyc == 30) START = 1'b0;
        end
        chk("b2b_count", dn, 3);
        chk("b2b_first", first_at, WIDTH + 1);
        chk("b2b_spacing", sp_ok, 1);
        repeat (3) @(negedge CLK);
        chk("b2b_idle", BUSY, 0);
        prev_d = '0; prev_bout = 1'b0;

`ifdef SERIAL_SUB_OVF_EN
        do_op(8'h80, 8'h01, 1'b0, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0);
`endif

        do_op(8'h00, 8'h00, 1'b1, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
